// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the decode-stage hazard scoreboard.
// The slot entry tracks one in-flight instruction between decode and writeback.
package hazard_scoreboard_pkg;

    localparam int unsigned SB_REG_AW = 5;
    localparam int unsigned SB_TW     = 3;
    localparam int unsigned FWD_RF    = 0;

    typedef struct packed {
        logic                 v;
        logic [SB_REG_AW-1:0] dst;
        logic                 we;
        logic [SB_TW-1:0]     tnew;
        logic                 c0w;
        logic                 md;
    } slot_t;

    function automatic int unsigned fsw_width(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide busy counter: loads a latency, counts down to zero.
// Freezes entirely while hold is high.
module md_busy_counter #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          busy
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!hold) begin
            if (load) begin
                cnt_d = load_val;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: shift-register of in-flight slots producing
// stall and per-source forward selects, plus MDU and CP0/ERET interlocks.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned STAGES  = 3,
    parameter int unsigned REG_AW  = SB_REG_AW,
    parameter int unsigned TW      = SB_TW,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10,
    parameter int unsigned FSW     = fsw_width(STAGES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hold,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
    input  logic [NUM_SRC*TW-1:0]     id_src_tuse,
    input  logic [REG_AW-1:0]         id_dst_addr,
    input  logic                      id_regwrite,
    input  logic [TW-1:0]             id_tnew,
    input  logic                      id_md_start,
    input  logic                      id_md_div,
    input  logic                      id_md_use,
    input  logic                      id_c0_write,
    input  logic                      id_eret,
    output logic                      stall,
    output logic [NUM_SRC*FSW-1:0]    fwd_sel,
    output logic                      md_busy
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CW      = $clog2(MAX_LAT + 1);

    slot_t slot_q [STAGES];
    slot_t slot_d [STAGES];

    logic [NUM_SRC*STAGES-1:0] match_flat;
    logic [NUM_SRC*FSW-1:0]    fwd_sel_c;
    logic                      data_stall;
    logic                      md_stall;
    logic                      cp0_stall;
    logic                      stall_int;
    logic                      md_busy_int;
    logic                      md_load;
    logic [CW-1:0]             md_load_val;
    logic                      any_c0w;

    // One comparator per (source, slot); register 0 never matches.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        for (genvar gk = 0; gk < STAGES; gk++) begin : g_slot
            assign match_flat[gi*STAGES+gk] =
                slot_q[gk].v && slot_q[gk].we &&
                (slot_q[gk].dst == id_src_addr[gi*REG_AW +: REG_AW]) &&
                (id_src_addr[gi*REG_AW +: REG_AW] != '0);
        end
    end

    // Lowest matching slot index is the youngest producer and wins.
    always_comb begin
        logic found;
        data_stall = 1'b0;
        fwd_sel_c  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            found = 1'b0;
            fwd_sel_c[i*FSW +: FSW] = FSW'(FWD_RF);
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (!found && match_flat[i*STAGES+k]) begin
                    found = 1'b1;
                    if (slot_q[k].tnew == '0) begin
                        fwd_sel_c[i*FSW +: FSW] = FSW'(k + 1);
                    end
                    if (slot_q[k].tnew > id_src_tuse[i*TW +: TW]) begin
                        data_stall = id_valid;
                    end
                end
            end
        end
    end

    always_comb begin
        any_c0w = 1'b0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (slot_q[k].v && slot_q[k].c0w) begin
                any_c0w = 1'b1;
            end
        end
    end

    assign md_stall  = id_valid && (id_md_use || id_md_start) &&
                       (md_busy_int || (slot_q[0].v && slot_q[0].md));
    assign cp0_stall = id_valid && id_eret && any_c0w;
    assign stall_int = data_stall || md_stall || cp0_stall;

    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            slot_d[k] = slot_q[k];
        end
        if (!hold) begin
            slot_d[0] = '0;
            if (id_valid && !stall_int) begin
                slot_d[0].v    = 1'b1;
                slot_d[0].dst  = id_dst_addr;
                slot_d[0].we   = id_regwrite;
                slot_d[0].tnew = id_tnew;
                slot_d[0].c0w  = id_c0_write;
                slot_d[0].md   = id_md_start;
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                slot_d[k] = slot_q[k-1];
                if (slot_q[k-1].tnew != '0) begin
                    slot_d[k].tnew = slot_q[k-1].tnew - TW'(1);
                end
            end
            if (flush) begin
                for (int unsigned k = 0; k < STAGES; k++) begin
                    slot_d[k].v = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    // The counter ignores flush: an issued mul/div always runs to completion.
    assign md_load     = id_valid && id_md_start && !stall_int && !hold;
    assign md_load_val = id_md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);

    md_busy_counter #(
        .CW (CW)
    ) u_md_busy_counter (
        .clk      (clk),
        .reset    (reset),
        .hold     (hold),
        .load     (md_load),
        .load_val (md_load_val),
        .busy     (md_busy_int)
    );

    assign stall   = reset ? 1'b0 : stall_int;
    assign fwd_sel = reset ? '0   : fwd_sel_c;
    assign md_busy = reset ? 1'b0 : md_busy_int;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed hazard scenarios plus
// randomized traffic, all checked against an issue-time based reference model.
module tb_hazard_scoreboard;

    localparam int unsigned NUM_SRC = 2;
    localparam int unsigned STAGES  = 3;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned TW      = 3;
    localparam int unsigned MUL_LAT = 5;
    localparam int unsigned DIV_LAT = 10;
    localparam int unsigned FSW     = 2;

    logic                      clk = 1'b0;
    logic                      reset, hold, flush, id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_src_addr;
    logic [NUM_SRC*TW-1:0]     id_src_tuse;
    logic [REG_AW-1:0]         id_dst_addr;
    logic                      id_regwrite;
    logic [TW-1:0]             id_tnew;
    logic                      id_md_start, id_md_div, id_md_use, id_c0_write, id_eret;
    logic                      stall, md_busy;
    logic [NUM_SRC*FSW-1:0]    fwd_sel;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_SRC (NUM_SRC),
        .STAGES  (STAGES),
        .REG_AW  (REG_AW),
        .TW      (TW),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .FSW     (FSW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hold        (hold),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_src_addr (id_src_addr),
        .id_src_tuse (id_src_tuse),
        .id_dst_addr (id_dst_addr),
        .id_regwrite (id_regwrite),
        .id_tnew     (id_tnew),
        .id_md_start (id_md_start),
        .id_md_div   (id_md_div),
        .id_md_use   (id_md_use),
        .id_c0_write (id_c0_write),
        .id_eret     (id_eret),
        .stall       (stall),
        .fwd_sel     (fwd_sel),
        .md_busy     (md_busy)
    );

    // Reference model: every issued instruction remembers the advance tick at
    // which it entered the pipe; its position and remaining T_new follow from age.
    typedef struct {
        int unsigned issue;
        int unsigned dst;
        bit          we;
        int unsigned tnew;
        bit          c0w;
        bit          md;
        bit          alive;
    } rec_t;

    rec_t        recs[$];
    int unsigned adv = 0;
    bit          md_valid = 1'b0;
    int unsigned md_adv = 0;
    int unsigned md_lat = 0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic                   exp_stall, exp_busy;
    logic [NUM_SRC*FSW-1:0] exp_fwd;
    logic                   obs_stall, obs_busy;
    logic [NUM_SRC*FSW-1:0] obs_fwd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic predict();
        int unsigned k, src, tuse, best, rem;
        bit slot0_md, any_c0;
        exp_stall = 1'b0;
        exp_fwd   = '0;
        exp_busy  = 1'b0;
        if (reset) return;
        exp_busy = md_valid && ((adv - md_adv) < md_lat);
        slot0_md = 1'b0;
        any_c0   = 1'b0;
        foreach (recs[j]) begin
            k = adv - recs[j].issue;
            if (recs[j].alive && k < STAGES) begin
                if (k == 0 && recs[j].md) slot0_md = 1'b1;
                if (recs[j].c0w) any_c0 = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src  = int'(id_src_addr[i*REG_AW +: REG_AW]);
            tuse = int'(id_src_tuse[i*TW +: TW]);
            best = STAGES;
            rem  = 0;
            foreach (recs[j]) begin
                k = adv - recs[j].issue;
                if (recs[j].alive && k < best && recs[j].we &&
                    recs[j].dst == src && src != 0) begin
                    best = k;
                    rem  = (recs[j].tnew > k) ? recs[j].tnew - k : 0;
                end
            end
            if (best < STAGES) begin
                if (rem == 0) exp_fwd[i*FSW +: FSW] = FSW'(best + 1);
                if (id_valid && rem > tuse) exp_stall = 1'b1;
            end
        end
        if (id_valid && (id_md_use || id_md_start) && (exp_busy || slot0_md)) exp_stall = 1'b1;
        if (id_valid && id_eret && any_c0) exp_stall = 1'b1;
    endtask

    task automatic model_edge();
        rec_t r;
        if (reset) begin
            recs.delete();
            md_valid = 1'b0;
        end else if (!hold) begin
            adv++;
            foreach (recs[j]) if (flush) recs[j].alive = 1'b0;
            if (id_valid && !exp_stall) begin
                r.issue = adv;
                r.dst   = int'(id_dst_addr);
                r.we    = id_regwrite;
                r.tnew  = int'(id_tnew);
                r.c0w   = id_c0_write;
                r.md    = id_md_start;
                r.alive = !flush;
                recs.push_back(r);
                if (id_md_start) begin
                    md_valid = 1'b1;
                    md_adv   = adv;
                    md_lat   = id_md_div ? DIV_LAT : MUL_LAT;
                end
            end
            while (recs.size() > 0 && (adv - recs[0].issue) >= STAGES) void'(recs.pop_front());
        end
    endtask

    // Inputs are set just after a falling edge; sample 1 ns later, then take the rising edge.
    task automatic cycle();
        #1;
        predict();
        obs_stall = stall;
        obs_busy  = md_busy;
        obs_fwd   = fwd_sel;
        check("stall",   32'(stall),   32'(exp_stall));
        check("fwd_sel", 32'(fwd_sel), 32'(exp_fwd));
        check("md_busy", 32'(md_busy), 32'(exp_busy));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 1'b0; hold = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_src_addr = '0; id_src_tuse = '0; id_dst_addr = '0; id_regwrite = 1'b0;
        id_tnew = '0; id_md_start = 1'b0; id_md_div = 1'b0; id_md_use = 1'b0;
        id_c0_write = 1'b0; id_eret = 1'b0;
    endtask

    task automatic writer(input int unsigned dst, input int unsigned tnew);
        idle();
        id_valid = 1'b1; id_regwrite = 1'b1;
        id_dst_addr = REG_AW'(dst); id_tnew = TW'(tnew);
    endtask

    task automatic reader(input int unsigned src, input int unsigned tuse);
        idle();
        id_valid = 1'b1;
        id_src_addr[REG_AW-1:0] = REG_AW'(src);
        id_src_tuse[TW-1:0]     = TW'(tuse);
    endtask

    int unsigned cnt;

    initial begin
        idle();
        reset = 1'b1;
        cycle();
        check("reset_stall", 32'(obs_stall), 32'd0);
        check("reset_busy",  32'(obs_busy),  32'd0);
        cycle();
        idle(); cycle();

        // ALU producer then consumers with different T_use
        writer(1, 1); cycle();
        reader(1, 1); cycle();
        reader(1, 0); cycle();
        idle(); repeat (3) cycle();

        // Load producer, consumer with T_use 0 stalls until ready
        writer(1, 2); cycle();
        reader(1, 0);
        for (int n = 0; n < 10; n++) begin cycle(); if (!obs_stall) break; end
        check("lw_release", 32'(obs_stall), 32'd0);
        idle(); repeat (3) cycle();

        // Register zero never matches
        writer(0, 2); cycle();
        reader(0, 0); cycle();
        check("r0_stall", 32'(obs_stall), 32'd0);
        check("r0_fwd",   32'(obs_fwd),   32'd0);
        idle(); repeat (3) cycle();

        // Two writers to $3; the younger (ready now) must be chosen over slot 1
        writer(3, 1); cycle();
        writer(3, 0); cycle();
        reader(3, 1); cycle();
        check("young_fwd", 32'(obs_fwd[FSW-1:0]), 32'd1);
        idle(); repeat (3) cycle();

        // Divide then mflo: stall while the MDU is busy
        idle(); id_valid = 1'b1; id_md_start = 1'b1; id_md_div = 1'b1; cycle();
        idle(); id_valid = 1'b1; id_md_use = 1'b1;
        cnt = 0;
        for (int n = 0; n < 20; n++) begin cycle(); if (!obs_stall) break; cnt++; end
        check("div_stall_cycles", cnt, 32'd10);
        idle(); repeat (3) cycle();

        // Flush mid-divide does not stop the counter
        idle(); id_valid = 1'b1; id_md_start = 1'b1; id_md_div = 1'b1; cycle();
        idle();
        cnt = 0;
        for (int n = 0; n < 30; n++) begin
            flush = (n == 2);
            cycle();
            if (!obs_busy) break;
            cnt++;
        end
        check("div_busy_cycles", cnt, 32'd10);
        idle(); repeat (2) cycle();

        // Hold during a load-use stall, then reset mid-stall
        writer(2, 3); cycle();
        reader(2, 0); cycle();
        hold = 1'b1;
        repeat (3) begin cycle(); check("hold_stall", 32'(obs_stall), 32'd1); end
        hold = 1'b0; cycle();
        reset = 1'b1; cycle();
        check("reset_mid_stall", 32'(obs_stall), 32'd0);
        reset = 1'b0; cycle();
        check("after_reset_fwd", 32'(obs_fwd), 32'd0);
        idle(); repeat (2) cycle();

        // MTC0 then ERET: ERET waits until MTC0 leaves the last slot
        idle(); id_valid = 1'b1; id_c0_write = 1'b1; cycle();
        idle(); id_valid = 1'b1; id_eret = 1'b1;
        cnt = 0;
        for (int n = 0; n < 10; n++) begin cycle(); if (!obs_stall) break; cnt++; end
        check("eret_stall_cycles", cnt, 32'd3);
        idle(); repeat (3) cycle();

        // Randomized traffic over a small register set to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            idle();
            id_valid = ($urandom_range(0, 9) < 8);
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                id_src_addr[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 3));
                id_src_tuse[i*TW +: TW]         = TW'($urandom_range(0, 3));
            end
            id_dst_addr = REG_AW'($urandom_range(0, 3));
            id_regwrite = ($urandom_range(0, 3) != 0);
            id_tnew     = TW'($urandom_range(0, 3));
            id_md_start = ($urandom_range(0, 19) == 0);
            id_md_div   = $urandom_range(0, 1) == 1;
            id_md_use   = ($urandom_range(0, 9) == 0);
            id_c0_write = ($urandom_range(0, 14) == 0);
            id_eret     = ($urandom_range(0, 14) == 0);
            hold        = ($urandom_range(0, 9) == 0);
            flush       = ($urandom_range(0, 24) == 0);
            reset       = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
